// File: rtl/dwc_window_gen.sv
// 3x3 valid-mode sliding-window generator for one channel of a raster pixel stream.
// Two line buffers hold rows r-1 and r-2. Each window is emitted one cycle after its bottom-right pixel.
module dwc_window_gen #(
  parameter int DWIDTH = 8,
  parameter int K_SIZE = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DWIDTH-1:0]               Pixel_In,
  input  logic                            Pixel_In_Valid,
  input  logic                            Frame_Clear,
  output logic [DWIDTH*K_SIZE*K_SIZE-1:0] Window_Out,
  output logic                            Window_Out_Valid,
  output logic                            Frame_Done
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NPIX = K_SIZE * K_SIZE;

  if (K_SIZE != 3) begin : g_ksize_check
    $error("dwc_window_gen: only K_SIZE = 3 is supported");
  end
  if (IMG_W < 3 || IMG_H < 3) begin : g_dim_check
    $error("dwc_window_gen: IMG_W and IMG_H must be at least 3");
  end

  logic [CW-1:0]          col_q, col_d, col_s;
  logic [RW-1:0]          row_q, row_d, row_s;
  logic [DWIDTH-1:0]      lb0_q [IMG_W];
  logic [DWIDTH-1:0]      lb1_q [IMG_W];
  logic [DWIDTH-1:0]      win_q [NPIX];
  logic [DWIDTH-1:0]      win_d [NPIX];
  logic [DWIDTH-1:0]      top_s, mid_s;
  logic [DWIDTH*NPIX-1:0] win_flat_s, wout_q, wout_d;
  logic                   wvalid_q, wvalid_d, done_q, done_d;
  logic                   emit_s, last_s;

  // Effective position of the incoming pixel: a clear takes effect before the pixel lands.
  always_comb begin
    col_s = col_q;
    row_s = row_q;
    if (Frame_Clear) begin
      col_s = {CW{1'b0}};
      row_s = {RW{1'b0}};
    end else begin
      col_s = col_q;
      row_s = row_q;
    end
    top_s  = lb1_q[col_s];
    mid_s  = lb0_q[col_s];
    emit_s = Pixel_In_Valid && (row_s >= RW'(2)) && (col_s >= CW'(2));
    last_s = (row_s == RW'(IMG_H - 1)) && (col_s == CW'(IMG_W - 1));
  end

  // Raster counters advance only on accepted pixels and wrap at end of frame.
  always_comb begin
    col_d = col_s;
    row_d = row_s;
    if (Pixel_In_Valid) begin
      if (col_s == CW'(IMG_W - 1)) begin
        col_d = {CW{1'b0}};
        if (row_s == RW'(IMG_H - 1)) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_s + RW'(1);
        end
      end else begin
        col_d = col_s + CW'(1);
      end
    end else begin
      col_d = col_s;
      row_d = row_s;
    end
  end

  // Window shifts left one column and loads {row r-2, row r-1, row r} on the right.
  always_comb begin
    for (int k = 0; k < NPIX; k++) begin
      win_d[k] = win_q[k];
    end
    if (Pixel_In_Valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = top_s;
      win_d[5] = mid_s;
      win_d[8] = Pixel_In;
    end else begin
      for (int k = 0; k < NPIX; k++) begin
        win_d[k] = win_q[k];
      end
    end
  end

  // Pack pixel 0 into the MSB slice; the output word only changes when a window is emitted.
  always_comb begin
    win_flat_s = {(DWIDTH*NPIX){1'b0}};
    for (int k = 0; k < NPIX; k++) begin
      win_flat_s[(NPIX-k)*DWIDTH-1 -: DWIDTH] = win_d[k];
    end
    wvalid_d = emit_s;
    done_d   = emit_s && last_s;
    if (emit_s) begin
      wout_d = win_flat_s;
    end else begin
      wout_d = wout_q;
    end
  end

  // Line buffers carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (Pixel_In_Valid) begin
      lb1_q[col_s] <= lb0_q[col_s];
      lb0_q[col_s] <= Pixel_In;
    end
  end

  // Counters, window shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q    <= {CW{1'b0}};
      row_q    <= {RW{1'b0}};
      wout_q   <= {(DWIDTH*NPIX){1'b0}};
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < NPIX; k++) begin
        win_q[k] <= {DWIDTH{1'b0}};
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      wout_q   <= wout_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
      for (int k = 0; k < NPIX; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign Window_Out       = wout_q;
  assign Window_Out_Valid = wvalid_q;
  assign Frame_Done       = done_q;

endmodule

// File: tb/tb_dwc_window_gen.sv
// Scoreboard bench for dwc_window_gen: a 4x4 instance for the frame scenarios, a 5x3 instance for extreme data.
module tb_dwc_window_gen;

  localparam int DW = 8;
  localparam int WW = DW * 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix4, pix5;
  logic          vld4, vld5, clr4, clr5;
  logic [WW-1:0] win4, win5;
  logic          wv4, wv5, fd4, fd5;

  int            checks = 0;
  int            errors = 0;
  logic [WW:0]   exp4[$];
  logic [WW:0]   exp5[$];
  logic [DW-1:0] img4 [4][4];
  int            m_row = 0;
  int            m_col = 0;
  logic [WW-1:0] last_exp4 = '0;
  logic [WW-1:0] last_exp5 = '0;

  always #5 clk = ~clk;

  dwc_window_gen #(.DWIDTH(DW), .K_SIZE(3), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .reset(rst), .Pixel_In(pix4), .Pixel_In_Valid(vld4), .Frame_Clear(clr4),
    .Window_Out(win4), .Window_Out_Valid(wv4), .Frame_Done(fd4));

  dwc_window_gen #(.DWIDTH(DW), .K_SIZE(3), .IMG_W(5), .IMG_H(3)) u_dut5 (
    .clk(clk), .reset(rst), .Pixel_In(pix5), .Pixel_In_Valid(vld5), .Frame_Clear(clr5),
    .Window_Out(win5), .Window_Out_Valid(wv5), .Frame_Done(fd5));

  function automatic logic [WW-1:0] mkwin(input int p[9]);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[(9-k)*DW-1 -: DW] = p[k][DW-1:0];
    end
    return w;
  endfunction

  // Reference model of the 4x4 instance: stores the frame and queues every expected window.
  task automatic m4_accept(input logic [DW-1:0] p, input bit clr);
    logic [WW-1:0] w;
    if (clr) begin
      m_row = 0;
      m_col = 0;
    end
    img4[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(9-(3*r+c))*DW-1 -: DW] = img4[m_row-2+r][m_col-2+c];
      exp4.push_back({(m_row == 3 && m_col == 3) ? 1'b1 : 1'b0, w});
    end
    if (m_col == 3) begin
      m_col = 0;
      m_row = (m_row == 3) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vld4 = 1'b0; vld5 = 1'b0; clr4 = 1'b0; clr5 = 1'b0;
    pix4 = 8'h00; pix5 = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({wv4, fd4, win4} !== {2'b00, {WW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_dut4 got v=%b d=%b w=%h expected all zero", wv4, fd4, win4);
    end
    checks++;
    if ({wv5, fd5, win5} !== {2'b00, {WW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_dut5 got v=%b d=%b w=%h expected all zero", wv5, fd5, win5);
    end
    rst = 1'b0;
    m_row = 0; m_col = 0; exp4.delete(); last_exp4 = '0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame(input string tag);
    logic [WW-1:0] got[8];
    logic [WW:0]   e;
    logic [WW-1:0] ref_w[4];
    int n = 0, first = -1, ndone = 0;
    ref_w[0] = mkwin('{1, 2, 3, 5, 6, 7, 9, 10, 11});
    ref_w[1] = mkwin('{2, 3, 4, 6, 7, 8, 10, 11, 12});
    ref_w[2] = mkwin('{5, 6, 7, 9, 10, 11, 13, 14, 15});
    ref_w[3] = mkwin('{6, 7, 8, 10, 11, 12, 14, 15, 16});
    for (int i = 1; i <= 17; i++) begin
      vld4 = (i <= 16) ? 1'b1 : 1'b0;
      pix4 = DW'(i);
      if (i <= 16) m4_accept(pix4, 1'b0);
      @(negedge clk);
      checks++;
      if (wv4 === 1'b1) begin
        if (exp4.size() == 0) begin
          errors++; $display("FAIL %s_extra_window got=%h", tag, win4);
        end else begin
          e = exp4.pop_front(); last_exp4 = e[WW-1:0];
          if ({fd4, win4} !== e) begin
            errors++; $display("FAIL %s_window got=%h expected=%h", tag, {fd4, win4}, e);
          end
        end
        if (first < 0) first = i;
        if (n < 8) got[n] = win4;
        n++;
        if (fd4 === 1'b1) ndone++;
      end else if (wv4 !== 1'b0 || fd4 !== 1'b0 || win4 !== last_exp4) begin
        errors++; $display("FAIL %s_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", tag, wv4, fd4, win4, last_exp4);
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL %s_count got=%0d expected=4", tag, n); end
    checks++;
    if (first != 11) begin errors++; $display("FAIL %s_first_latency got pixel %0d expected pixel 11", tag, first); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL %s_frame_done got=%0d expected=1", tag, ndone); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < n && got[k] !== ref_w[k]) begin
        errors++; $display("FAIL %s_const_window%0d got=%h expected=%h", tag, k, got[k], ref_w[k]);
      end else if (k >= n) begin
        errors++; $display("FAIL %s_const_window%0d got=missing expected=%h", tag, k, ref_w[k]);
      end
    end
  endtask

  task automatic test_valid_gaps;
    logic [WW:0] e;
    int n = 0, gap;
    for (int i = 1; i <= 17; i++) begin
      gap = ((i % 4) == 1) ? 2 + $urandom_range(3, 0) : $urandom_range(5, 0);
      for (int g = 0; g <= gap; g++) begin
        vld4 = (g == gap && i <= 16) ? 1'b1 : 1'b0;
        pix4 = (g == gap) ? DW'(i) : 8'hEE;
        if (vld4) m4_accept(pix4, 1'b0);
        @(negedge clk);
        checks++;
        if (wv4 === 1'b1) begin
          n++;
          if (exp4.size() == 0) begin
            errors++; $display("FAIL gaps_extra_window got=%h", win4);
          end else begin
            e = exp4.pop_front(); last_exp4 = e[WW-1:0];
            if ({fd4, win4} !== e) begin
              errors++; $display("FAIL gaps_window got=%h expected=%h", {fd4, win4}, e);
            end
          end
        end else if (wv4 !== 1'b0 || fd4 !== 1'b0 || win4 !== last_exp4) begin
          errors++; $display("FAIL gaps_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", wv4, fd4, win4, last_exp4);
        end
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL gaps_count got=%0d expected=4", n); end
  endtask

  task automatic test_back_to_back;
    logic [WW:0]   e;
    logic [WW-1:0] first_b;
    int n = 0, ndone = 0, b_pix = -1;
    for (int i = 1; i <= 33; i++) begin
      vld4 = (i <= 32) ? 1'b1 : 1'b0;
      pix4 = (i <= 16) ? DW'(i) : DW'(i + 84);
      if (i <= 32) m4_accept(pix4, 1'b0);
      @(negedge clk);
      checks++;
      if (wv4 === 1'b1) begin
        if (exp4.size() == 0) begin
          errors++; $display("FAIL b2b_extra_window got=%h", win4);
        end else begin
          e = exp4.pop_front(); last_exp4 = e[WW-1:0];
          if ({fd4, win4} !== e) begin
            errors++; $display("FAIL b2b_window got=%h expected=%h", {fd4, win4}, e);
          end
        end
        if (n == 4) begin b_pix = i; first_b = win4; end
        n++;
        if (fd4 === 1'b1) ndone++;
      end else if (wv4 !== 1'b0 || fd4 !== 1'b0 || win4 !== last_exp4) begin
        errors++; $display("FAIL b2b_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", wv4, fd4, win4, last_exp4);
      end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL b2b_count got=%0d expected=8", n); end
    checks++;
    if (ndone != 2) begin errors++; $display("FAIL b2b_frame_done got=%0d expected=2", ndone); end
    checks++;
    if (b_pix != 27 || first_b !== mkwin('{101, 102, 103, 105, 106, 107, 109, 110, 111})) begin
      errors++; $display("FAIL b2b_first_b got pixel %0d w=%h expected pixel 27 w=%h", b_pix, first_b,
                         mkwin('{101, 102, 103, 105, 106, 107, 109, 110, 111}));
    end
  endtask

  task automatic test_frame_clear;
    logic [WW:0]   e;
    logic [WW-1:0] first_w;
    int n = 0;
    for (int i = 1; i <= 24; i++) begin
      vld4 = (i <= 23) ? 1'b1 : 1'b0;
      clr4 = (i == 8) ? 1'b1 : 1'b0;
      pix4 = (i <= 7) ? DW'(i) : DW'(i + 193);
      if (i <= 23) m4_accept(pix4, clr4);
      @(negedge clk);
      clr4 = 1'b0;
      checks++;
      if (wv4 === 1'b1) begin
        if (exp4.size() == 0) begin
          errors++; $display("FAIL clear_extra_window got=%h", win4);
        end else begin
          e = exp4.pop_front(); last_exp4 = e[WW-1:0];
          if ({fd4, win4} !== e) begin
            errors++; $display("FAIL clear_window got=%h expected=%h", {fd4, win4}, e);
          end
        end
        if (n == 0) first_w = win4;
        n++;
      end else if (wv4 !== 1'b0 || fd4 !== 1'b0 || win4 !== last_exp4) begin
        errors++; $display("FAIL clear_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", wv4, fd4, win4, last_exp4);
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL clear_count got=%0d expected=4", n); end
    checks++;
    if (n > 0 && first_w !== mkwin('{201, 202, 203, 205, 206, 207, 209, 210, 211})) begin
      errors++; $display("FAIL clear_first_window got=%h expected=%h", first_w,
                         mkwin('{201, 202, 203, 205, 206, 207, 209, 210, 211}));
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [WW:0] e;
    int n = 0;
    for (int i = 1; i <= 12; i++) begin
      vld4 = 1'b1;
      pix4 = DW'(i);
      m4_accept(pix4, 1'b0);
      @(negedge clk);
      checks++;
      if (wv4 === 1'b1) begin
        n++;
        if (exp4.size() == 0) begin
          errors++; $display("FAIL rstmid_extra_window got=%h", win4);
        end else begin
          e = exp4.pop_front(); last_exp4 = e[WW-1:0];
          if ({fd4, win4} !== e) begin
            errors++; $display("FAIL rstmid_window got=%h expected=%h", {fd4, win4}, e);
          end
        end
      end else if (wv4 !== 1'b0 || fd4 !== 1'b0 || win4 !== last_exp4) begin
        errors++; $display("FAIL rstmid_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", wv4, fd4, win4, last_exp4);
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL rstmid_pre_count got=%0d expected=2", n); end
    vld4 = 1'b0;
    rst  = 1'b1;
    #1;
    checks++;
    if ({wv4, fd4, win4} !== {2'b00, {WW{1'b0}}}) begin
      errors++; $display("FAIL rstmid_async_clear got v=%b d=%b w=%h expected all zero", wv4, fd4, win4);
    end
    @(negedge clk);
    rst = 1'b0;
    m_row = 0; m_col = 0; exp4.delete(); last_exp4 = '0;
    @(negedge clk);
    test_basic_frame("rstmid_rerun");
  endtask

  task automatic test_signed_extreme;
    logic [WW:0]   e;
    logic [WW-1:0] w;
    logic [WW-1:0] first_w;
    int n = 0, r, c;
    for (int i = 0; i <= 15; i++) begin
      vld5 = (i <= 14) ? 1'b1 : 1'b0;
      pix5 = ((i % 2) == 0) ? 8'h80 : 8'h7F;
      r = i / 5; c = i % 5;
      if (i <= 14 && r >= 2 && c >= 2) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            w[(9-(3*rr+cc))*DW-1 -: DW] = ((((r-2+rr)*5 + (c-2+cc)) % 2) == 0) ? 8'h80 : 8'h7F;
        exp5.push_back({(c == 4) ? 1'b1 : 1'b0, w});
      end
      @(negedge clk);
      checks++;
      if (wv5 === 1'b1) begin
        if (exp5.size() == 0) begin
          errors++; $display("FAIL signed_extra_window got=%h", win5);
        end else begin
          e = exp5.pop_front(); last_exp5 = e[WW-1:0];
          if ({fd5, win5} !== e) begin
            errors++; $display("FAIL signed_window got=%h expected=%h", {fd5, win5}, e);
          end
        end
        if (n == 0) first_w = win5;
        n++;
      end else if (wv5 !== 1'b0 || fd5 !== 1'b0 || win5 !== last_exp5) begin
        errors++; $display("FAIL signed_idle got v=%b d=%b w=%h expected v=0 d=0 w=%h", wv5, fd5, win5, last_exp5);
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL signed_count got=%0d expected=3", n); end
    checks++;
    if (first_w !== 72'h807F80_7F807F_807F80) begin
      errors++; $display("FAIL signed_first_window got=%h expected=807f807f807f807f80", first_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame("basic");
    test_valid_gaps();
    test_back_to_back();
    test_frame_clear();
    test_reset_mid_frame();
    test_signed_extreme();
    checks++;
    if (exp4.size() != 0 || exp5.size() != 0) begin
      errors++; $display("FAIL leftover_expected got=%0d/%0d pending expected=0/0", exp4.size(), exp5.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
